// File: rtl/disp_conf_upsampler.sv
// Rebuilds a full-resolution {disp, conf} stream from the decimated one:
// horizontal repeat from the output register, vertical repeat from a one-row line buffer.
module disp_conf_upsampler #(
  parameter int disp_bits        = 5,
  parameter int dec_factor       = 2,
  parameter int dec_frame_width  = 240,
  parameter int dec_frame_height = 180
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [disp_bits+7:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             conf_thresh,
  output logic [disp_bits-1:0]   out_disp,
  output logic [7:0]             out_conf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_sol,
  output logic                   out_eol
);

  localparam int DW = disp_bits + 8;
  localparam int CW = (dec_frame_width > 1) ? $clog2(dec_frame_width) : 1;
  localparam int HW = $clog2(dec_factor);
  localparam int RW = (dec_frame_height > 1) ? $clog2(dec_frame_height) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(dec_frame_width - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(dec_factor - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(dec_frame_height - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t          state_q;
  logic [CW-1:0]   col_q, col_d;
  logic [HW-1:0]   h_cnt_q, v_cnt_q;
  logic [RW-1:0]   row_q;
  logic [DW-1:0]   out_data_q;
  logic            out_valid_q, sof_q, sol_q, eol_q;

  logic [DW-1:0]   line_buf [dec_frame_width];
  logic [DW-1:0]   rd_data_q;

  logic                 advance, accept, step;
  logic                 last_h, last_col, last_v;
  logic                 sol_c, eol_c, sof_c;
  logic [disp_bits-1:0] disp_m;

  // Handshake: a word moves on a port in any cycle where its valid and ready are
  // both high; out_* stay frozen while out_valid is high and out_ready is low.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = !reset && (state_q == FILL) && advance && (h_cnt_q == '0);
  assign accept   = in_valid && in_ready;

  assign last_h   = (h_cnt_q == REP_LAST);
  assign last_col = (col_q == COL_LAST);
  assign last_v   = (v_cnt_q == REP_LAST);

  assign sol_c = (col_q == '0) && (h_cnt_q == '0);
  assign eol_c = last_col && last_h;
  assign sof_c = sol_c && (v_cnt_q == '0) && (row_q == '0);

  assign disp_m = (in_data[7:0] < conf_thresh) ? '0 : in_data[DW-1:8];

  // step: the output register takes a new pixel this cycle.
  always_comb begin
    step = 1'b0;
    if (state_q == FILL) step = accept || (advance && (h_cnt_q != '0));
    else                 step = advance;
    col_d = col_q;
    if (step && last_h) col_d = last_col ? '0 : col_q + 1'b1;
  end

  // Reading at the next column keeps rd_data_q == line_buf[col_q] one cycle
  // ahead of its use, so REPLAY never waits on the RAM.
  always_ff @(posedge clk) begin
    if (accept) line_buf[col_q] <= {disp_m, in_data[7:0]};
    rd_data_q <= line_buf[col_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      col_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q <= col_d;
      case (state_q)
        FILL: begin
          if (accept) begin
            out_data_q  <= {disp_m, in_data[7:0]};
            out_valid_q <= 1'b1;
            {sof_q, sol_q, eol_q} <= {sof_c, sol_c, eol_c};
            h_cnt_q     <= HW'(1);
          end else if (advance && (h_cnt_q != '0)) begin
            out_valid_q <= 1'b1;
            {sof_q, sol_q, eol_q} <= {sof_c, sol_c, eol_c};
            h_cnt_q     <= last_h ? '0 : h_cnt_q + 1'b1;
            if (last_h && last_col) begin
              v_cnt_q <= HW'(1);
              state_q <= REPLAY;
            end
          end else if (advance) begin
            out_valid_q <= 1'b0;
          end
        end
        REPLAY: begin
          if (advance) begin
            out_data_q  <= rd_data_q;
            out_valid_q <= 1'b1;
            {sof_q, sol_q, eol_q} <= {sof_c, sol_c, eol_c};
            h_cnt_q     <= last_h ? '0 : h_cnt_q + 1'b1;
            if (last_h && last_col) begin
              if (last_v) begin
                v_cnt_q <= '0;
                state_q <= FILL;
                row_q   <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
              end else begin
                v_cnt_q <= v_cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_disp  = out_data_q[DW-1:8];
  assign out_conf  = out_data_q[7:0];
  assign out_valid = out_valid_q;
  assign out_sof   = sof_q;
  assign out_sol   = sol_q;
  assign out_eol   = eol_q;

endmodule

// File: tb/tb_disp_conf_upsampler.sv
// Directed bench for disp_conf_upsampler: 4x2 decimated frames, factor 2,
// expected pixels queued per decimated row and compared in order.
module tb_disp_conf_upsampler;

  localparam int DB = 5;
  localparam int F  = 2;
  localparam int W  = 4;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB+7:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    conf_thresh;
  logic [DB-1:0] out_disp;
  logic [7:0]    out_conf;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof, out_sol, out_eol;

  disp_conf_upsampler #(
    .disp_bits(DB), .dec_factor(F), .dec_frame_width(W), .dec_frame_height(H)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .conf_thresh(conf_thresh),
    .out_disp(out_disp), .out_conf(out_conf), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_sol(out_sol), .out_eol(out_eol)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {sof, sol, eol, disp, conf}
  logic [15:0]   exp_q[$];
  logic [DB+7:0] in_q[$];
  int            acc_cyc[$];
  int            cyc = 0;
  int            first_out;
  int            bubbles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Arrays are packed col 3 .. col 0; d_exp is the hand-computed post-threshold disparity.
  task automatic push_row(input int row, input logic [3:0][DB-1:0] d_in,
                          input logic [3:0][DB-1:0] d_exp, input logic [3:0][7:0] cf);
    logic sol, eol, sof;
    for (int c = 0; c < W; c++) in_q.push_back({d_in[c], cf[c]});
    for (int v = 0; v < F; v++)
      for (int c = 0; c < W; c++)
        for (int h = 0; h < F; h++) begin
          sol = (c == 0) && (h == 0);
          eol = (c == W - 1) && (h == F - 1);
          sof = sol && (v == 0) && (row == 0);
          exp_q.push_back({sof, sol, eol, d_exp[c], cf[c]});
        end
  endtask

  // driver + monitor: drive #1 after posedge, observe at negedge
  task automatic run(input int stop_after, input bit rand_ready, input bit rand_valid);
    int          popped = 0;
    int          budget = 2000;
    bit          holding = 0;
    bit          seen = 0;
    logic [15:0] held, obs;
    acc_cyc.delete();
    bubbles = 0;
    first_out = -1;
    while (exp_q.size() > 0 && popped < stop_after && budget > 0) begin
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = in_q[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      budget--;
      obs = {out_sof, out_sol, out_eol, out_disp, out_conf};
      if (holding) check("hold", {15'd0, out_valid, obs}, {15'd0, 1'b1, held});
      holding = out_valid && !out_ready;
      held = obs;
      if (out_valid) begin
        if (!seen) first_out = cyc;
        seen = 1;
      end else if (seen) begin
        bubbles++;
      end
      if (out_valid && out_ready) begin
        check("pix", 32'(obs), 32'(exp_q.pop_front()));
        popped++;
      end
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        acc_cyc.push_back(cyc);
      end
    end
    check("pixel_count", popped, stop_after);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_flags", 32'({out_sof, out_sol, out_eol}), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    conf_thresh = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_flags", 32'({out_sof, out_sol, out_eol}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // full rate, three decimated rows: row replication, replay timing, frame wrap
    push_row(0, {5'd4, 5'd3, 5'd2, 5'd1},   {5'd4, 5'd3, 5'd2, 5'd1},   {4{8'd50}});
    push_row(1, {5'd8, 5'd7, 5'd6, 5'd5},   {5'd8, 5'd7, 5'd6, 5'd5},   {4{8'd51}});
    push_row(0, {5'd12, 5'd11, 5'd10, 5'd9}, {5'd12, 5'd11, 5'd10, 5'd9}, {4{8'd52}});
    run(48, 1'b0, 1'b0);
    check("accepts", acc_cyc.size(), 12);
    if (acc_cyc.size() >= 9) begin
      check("latency", first_out, acc_cyc[0] + 1);
      check("replay_gap_r0", acc_cyc[4] - acc_cyc[3], 10);
      check("replay_gap_r1", acc_cyc[8] - acc_cyc[7], 10);
    end
    check("bubbles", bubbles, 0);
    do_reset();

    // random backpressure and input gaps, same three rows
    push_row(0, {5'd4, 5'd3, 5'd2, 5'd1},   {5'd4, 5'd3, 5'd2, 5'd1},   {4{8'd50}});
    push_row(1, {5'd8, 5'd7, 5'd6, 5'd5},   {5'd8, 5'd7, 5'd6, 5'd5},   {4{8'd51}});
    push_row(0, {5'd12, 5'd11, 5'd10, 5'd9}, {5'd12, 5'd11, 5'd10, 5'd9}, {4{8'd52}});
    run(48, 1'b1, 1'b1);
    check("bp_drained", exp_q.size(), 0);
    do_reset();

    // confidence threshold 100: conf 99 -> 0, conf 100 -> 7, conf 255 -> 31, conf 0 -> 0
    conf_thresh = 8'd100;
    push_row(0, {5'd5, 5'd31, 5'd7, 5'd7}, {5'd0, 5'd31, 5'd7, 5'd0},
             {8'd0, 8'd255, 8'd100, 8'd99});
    run(16, 1'b0, 1'b0);
    do_reset();
    conf_thresh = 8'd0;

    // reset during the replayed sub-row
    push_row(0, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd4, 5'd3, 5'd2, 5'd1}, {4{8'd50}});
    run(10, 1'b0, 1'b0);
    exp_q.delete();
    in_q.delete();
    do_reset();
    push_row(0, {5'd12, 5'd11, 5'd10, 5'd9}, {5'd12, 5'd11, 5'd10, 5'd9}, {4{8'd60}});
    run(16, 1'b0, 1'b0);
    check("post_reset_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/disp_conf_upsampler.md
Name: disp_conf_upsampler

Overview:
Consumer of the decimated disparity/confidence stream produced by the disparity filtering stage. Takes {disp, conf} samples at decimated resolution over a valid/ready handshake. Replicates each sample dec_factor times horizontally, and each decimated row dec_factor times vertically using a one-row line buffer, to rebuild a full-resolution stream. Also zeroes disparity for samples below a confidence threshold and tags the stream with start-of-frame, start-of-line and end-of-line flags for the display/compositing path.

Parameters:
disp_bits, 5, disparity width in bits
dec_factor, 2, decimation factor per axis; power of two, >= 2
dec_frame_width, 240, decimated samples per row
dec_frame_height, 180, decimated rows per frame

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_data  in  disp_bits+8  {disp[disp_bits-1:0], conf[7:0]}, disp in the MSBs
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
conf_thresh  in  8  confidence threshold, unsigned
out_disp  out  disp_bits  full-resolution disparity
out_conf  out  8  full-resolution confidence
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_sof  out  1  first pixel of frame
out_sol  out  1  first pixel of full-res row
out_eol  out  1  last pixel of full-res row

Behaviour:
- Reset: out_valid=0, in_ready=0, out_sof/sol/eol=0, state=FILL, col/h_cnt/v_cnt/row counters=0. Line buffer contents are not reset. Reset mid-frame discards all in-flight data. The next accepted sample is pixel 0 of a new frame.
- Transfer happens on valid&&ready on either port. out_* are registered and held stable while out_valid && !out_ready.
- advance = !out_valid || out_ready.
- Capture: on input accept, disp_m = (conf < conf_thresh) ? 0 : disp. conf passes unchanged. conf_thresh is sampled per accepted sample. {disp_m, conf} is written to line_buf[col].
- State FILL, first sub-row of a decimated row (v_cnt=0):
  - in_ready = advance && h_cnt==0.
  - On accept, the output register loads the sample, out_valid=1 the next cycle, and h_cnt=1. Latency is 1 cycle from input accept to out_valid.
  - Each later advance with h_cnt!=0 re-emits the same value. h_cnt increments and wraps to 0 after dec_factor-1.
  - On the final repeat of col=dec_frame_width-1, col wraps to 0, v_cnt=1, and state goes to REPLAY.
  - in_valid low leaves a bubble (out_valid drops after the pending pixel is taken). There is no loss.
- State REPLAY (v_cnt=1..dec_factor-1):
  - in_ready=0.
  - Output comes from line_buf[col], each entry emitted dec_factor times.
  - Line buffer is synchronous-read RAM. Reads are prefetched so that sustained out_ready=1 gives 1 pixel/cycle with no bubbles, including across sub-row boundaries and the REPLAY->FILL transition (FILL still depends on in_valid).
  - After the last pixel of sub-row dec_factor-1: v_cnt=0, state=FILL, and the decimated row counter increments, wrapping to 0 after dec_frame_height-1.
- Flags are valid with out_valid and held with data:
  - out_sol when col=0, h_cnt=0.
  - out_eol when col=dec_frame_width-1 and last horizontal repeat.
  - out_sof when out_sol && v_cnt=0 && row=0.
- Throughput: full-res frame = dec_frame_width*dec_factor pixels x dec_frame_height*dec_factor rows. Input duty is at most 1/(dec_factor^2) averaged.
- No overflow is possible: input is only accepted when the output slot frees.

Test Plan:
- Row replication: dec_factor=2, dec_frame_width=4, conf_thresh=0. Feed disp 1,2,3,4 (conf 50), out_ready=1. Output must be 1,1,2,2,3,3,4,4 then the same again. out_sol on pixels 0 and 8, out_eol on pixels 7 and 15, out_sof only on pixel 0.
- Backpressure: random out_ready (50%) across 3 decimated rows. Sequence must be identical to the out_ready=1 run. Data and flags must be stable while out_valid && !out_ready. No drop or duplicate.
- Threshold: conf_thresh=100. Sample {disp 7, conf 99} must output disp 0, conf 99. Sample {disp 7, conf 100} must output disp 7, conf 100. Sample {disp 31, conf 255} must output disp 31.
- Input stall in REPLAY: in_valid held high throughout. in_ready must be 0 for exactly the 8 REPLAY output cycles (width 4, factor 2, out_ready=1). Must be 0 bubbles at the REPLAY->FILL transition.
- Frame wrap: dec_frame_height=2, stream 3 decimated rows. out_sof must assert on the first pixel and again on the first pixel of decimated row 2 (full-res row 4).
- Reset mid-REPLAY: assert reset 1 cycle during sub-row 1. out_valid must be 0 the next cycle. The next accepted sample must emerge with out_sof=1 and be replicated normally.
